// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
//   ctrl_state_e : sequencer state as reported on ctrl_state
//   stage_ctl_t  : 7-bit bundle of PC / pipeline-register enables and clears
//   REG_X0       : architectural zero register index
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } ctrl_state_e;

  localparam int unsigned REG_X0 = 0;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
  } stage_ctl_t;

endpackage

// File: rtl/hazard_luse_detect.sv
// Load-use hazard compare: flags when the ID instruction reads a register
// that the load currently in EX will write. x0 never hazards.
// Ports:
//   i_id_rs1/i_id_rs2         source registers of the ID instruction
//   i_id_uses_rs1/i_id_uses_rs2 source-valid qualifiers
//   i_ex_rd, i_ex_mem_read    destination and load flag of the EX instruction
//   o_luse                    hazard present
module hazard_luse_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned RF_ADDR_W = 5
) (
  input  logic [RF_ADDR_W-1:0] i_id_rs1,
  input  logic [RF_ADDR_W-1:0] i_id_rs2,
  input  logic                 i_id_uses_rs1,
  input  logic                 i_id_uses_rs2,
  input  logic [RF_ADDR_W-1:0] i_ex_rd,
  input  logic                 i_ex_mem_read,
  output logic                 o_luse
);

  logic w_rd_nz;
  logic w_hit1;
  logic w_hit2;

  assign w_rd_nz = (i_ex_rd != RF_ADDR_W'(REG_X0));
  assign w_hit1  = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_hit2  = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
  assign o_luse  = i_ex_mem_read && w_rd_nz && (w_hit1 || w_hit2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32I pipeline.
// Drives PC and IF/ID, ID/EX, EX/MEM, MEM/WB enables and clears from
// load-use hazards, EX-resolved mispredicts and memory wait states, and
// tracks a wrong-path fetch still in flight (squash_pend).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   id_*, ex_rd, ex_mem_read     load-use hazard inputs
//   ex_mispredict                redirect request from EX
//   imem_ready, mem_access, dmem_ready  memory handshakes
//   pc_en .. memwb_en            stage controls (combinational)
//   ctrl_state, squash_pend      registered sequencer status
// Optional: define HAZARD_PERF_CNT_EN to add saturating stall_cycles and
// flush_count outputs (CNT_W bits each).
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned RF_ADDR_W = 5,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RF_ADDR_W-1:0] id_rs1,
  input  logic [RF_ADDR_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [RF_ADDR_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 ex_mispredict,
  input  logic                 imem_ready,
  input  logic                 mem_access,
  input  logic                 dmem_ready,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 ifid_flush,
  output logic                 idex_en,
  output logic                 idex_flush,
  output logic                 exmem_en,
  output logic                 memwb_en,
  output logic [1:0]           ctrl_state,
  output logic                 squash_pend
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_count
`endif
);

  ctrl_state_e r_state;
  logic        r_squash;
  ctrl_state_e w_next_state;
  logic        w_next_squash;
  stage_ctl_t  w_ctl;
  logic        w_luse;
  logic        w_dstall;

  hazard_luse_detect #(.RF_ADDR_W(RF_ADDR_W)) u_luse (
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_uses_rs1 (id_uses_rs1),
    .i_id_uses_rs2 (id_uses_rs2),
    .i_ex_rd       (ex_rd),
    .i_ex_mem_read (ex_mem_read),
    .o_luse        (w_luse)
  );

  assign w_dstall = mem_access && !dmem_ready;

  // Strict priority: reset, data stall, mispredict, squash, load-use, fetch wait.
  always_comb begin
    w_ctl         = '1;
    w_ctl.ifid_flush = 1'b0;
    w_ctl.idex_flush = 1'b0;
    w_next_state  = ST_RUN;
    w_next_squash = r_squash;
    if (rst) begin
      w_ctl            = '0;
      w_ctl.ifid_flush = 1'b1;
      w_ctl.idex_flush = 1'b1;
      w_next_squash    = 1'b0;
    end else if (w_dstall) begin
      // Whole pipe frozen; a mispredict in EX re-evaluates on release.
      w_ctl        = '0;
      w_next_state = ST_MEM_WAIT;
    end else if (ex_mispredict) begin
      w_ctl.ifid_flush = 1'b1;
      w_ctl.idex_flush = 1'b1;
      w_next_squash    = !imem_ready;
    end else if (r_squash) begin
      // PC holds the target; the wrong-path response is dropped on arrival.
      w_ctl.pc_en      = 1'b0;
      w_ctl.ifid_flush = 1'b1;
      if (imem_ready) w_next_squash = 1'b0;
    end else if (w_luse) begin
      w_ctl.pc_en      = 1'b0;
      w_ctl.ifid_en    = 1'b0;
      w_ctl.idex_flush = 1'b1;
      w_next_state     = ST_LOAD_STALL;
    end else if (!imem_ready) begin
      w_ctl.pc_en      = 1'b0;
      w_ctl.ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_squash <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_squash <= w_next_squash;
    end
  end

  assign pc_en       = w_ctl.pc_en;
  assign ifid_en     = w_ctl.ifid_en;
  assign ifid_flush  = w_ctl.ifid_flush;
  assign idex_en     = w_ctl.idex_en;
  assign idex_flush  = w_ctl.idex_flush;
  assign exmem_en    = w_ctl.exmem_en;
  assign memwb_en    = w_ctl.memwb_en;
  assign ctrl_state  = r_state;
  assign squash_pend = r_squash;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_ctl.pc_en && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (ex_mispredict && !w_dstall && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cycles = r_stall_cnt;
  assign flush_count  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int unsigned RW = 5;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_mispredict;
  logic          imem_ready, mem_access, dmem_ready;
  logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
  logic [1:0]    ctrl_state;
  logic          squash_pend;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] stall_cycles, flush_count;
`endif

  pipeline_hazard_ctrl #(.RF_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mispredict(ex_mispredict),
    .imem_ready(imem_ready), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ctrl_state(ctrl_state), .squash_pend(squash_pend)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state (what the controller should currently hold)
  int          m_state;  // 0 RUN, 1 LOAD_STALL, 2 MEM_WAIT
  bit          m_sq;
  int unsigned m_stall, m_flush;

  // Per-cycle observation/expectation, bundle order:
  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
  logic [6:0] o_b, e_b;
  logic [1:0] o_st;
  logic       o_sq;
  int         e_st;
  bit         e_sq;
  int unsigned e_stall, e_flush;
  logic [CW-1:0] o_stall, o_flush;

  task automatic set_idle();
    rst = 0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0; ex_mispredict = 0;
    imem_ready = 1; mem_access = 0; dmem_ready = 1;
  endtask

  // Behavioural rules: returns expected controls and next model state.
  task automatic model(output logic [6:0] b, output int nst, output bit nsq);
    bit dstall, luse, hit1, hit2;
    dstall = mem_access && !dmem_ready;
    hit1 = id_uses_rs1 && (id_rs1 == ex_rd);
    hit2 = id_uses_rs2 && (id_rs2 == ex_rd);
    luse = ex_mem_read && (ex_rd != 0) && (hit1 || hit2);
    nst = 0;
    nsq = m_sq;
    if (rst)                begin b = 7'b0010100; nsq = 0; end
    else if (dstall)        begin b = 7'b0000000; nst = 2; end
    else if (ex_mispredict) begin b = 7'b1111111; nsq = !imem_ready; end
    else if (m_sq)          begin b = 7'b0111011; if (imem_ready) nsq = 0; end
    else if (luse)          begin b = 7'b0001111; nst = 1; end
    else if (!imem_ready)   b = 7'b0111011;
    else                    b = 7'b1101011;
  endtask

  // Advance one clock: capture outputs mid-cycle, then step the model at the edge.
  task automatic tick();
    int nst;
    bit nsq;
    @(negedge clk);
    model(e_b, nst, nsq);
    e_st = m_state; e_sq = m_sq; e_stall = m_stall; e_flush = m_flush;
    o_b  = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en};
    o_st = ctrl_state; o_sq = squash_pend;
`ifdef HAZARD_PERF_CNT_EN
    o_stall = stall_cycles; o_flush = flush_count;
`else
    o_stall = '0; o_flush = '0;
`endif
    @(posedge clk);
    if (rst) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (!e_b[6] && m_stall < (2**CW - 1)) m_stall++;
      if (ex_mispredict && !(mem_access && !dmem_ready) && m_flush < (2**CW - 1)) m_flush++;
    end
    m_state = nst; m_sq = nsq;
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1;
    @(posedge clk); #1;
    m_state = 0; m_sq = 0; m_stall = 0; m_flush = 0;
    tick();
    checks++; if (o_b !== 7'b0010100) begin errors++; $display("FAIL reset_ctl got %b exp %b", o_b, 7'b0010100); end
    checks++; if (o_st !== 2'd0 || o_sq !== 1'b0) begin errors++; $display("FAIL reset_state got st=%0d sq=%b exp st=0 sq=0", o_st, o_sq); end
    rst = 0;
    tick();
    checks++; if (o_b !== 7'b1101011) begin errors++; $display("FAIL run_ctl got %b exp %b", o_b, 7'b1101011); end
  endtask

  task automatic test_load_use();
    set_idle();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    tick();
    checks++; if (o_b !== 7'b0001111) begin errors++; $display("FAIL luse_ctl got %b exp %b", o_b, 7'b0001111); end
    set_idle();
    tick();
    checks++; if (o_st !== 2'd1) begin errors++; $display("FAIL luse_state got %0d exp 1", o_st); end
    checks++; if (o_b !== 7'b1101011) begin errors++; $display("FAIL luse_release got %b exp %b", o_b, 7'b1101011); end
    // rs2 path, and x0 never stalls
    ex_mem_read = 1; ex_rd = 9; id_rs2 = 9; id_uses_rs2 = 1;
    tick();
    checks++; if (o_b !== 7'b0001111) begin errors++; $display("FAIL luse_rs2 got %b exp %b", o_b, 7'b0001111); end
    set_idle();
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1; id_rs2 = 0; id_uses_rs2 = 1;
    tick();
    checks++; if (o_b !== 7'b1101011) begin errors++; $display("FAIL luse_x0 got %b exp %b", o_b, 7'b1101011); end
    set_idle();
    tick();
    checks++; if (o_st !== 2'd0) begin errors++; $display("FAIL luse_x0_state got %0d exp 0", o_st); end
  endtask

  task automatic test_mispredict_squash();
    set_idle();
    ex_mispredict = 1; imem_ready = 0;
    tick();
    checks++; if (o_b !== 7'b1111111) begin errors++; $display("FAIL mp_ctl got %b exp %b", o_b, 7'b1111111); end
    ex_mispredict = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (o_b !== 7'b0111011 || o_sq !== 1'b1) begin errors++; $display("FAIL mp_squash%0d got %b sq=%b exp %b sq=1", i, o_b, o_sq, 7'b0111011); end
    end
    imem_ready = 1;
    tick();
    checks++; if (o_b !== 7'b0111011 || o_sq !== 1'b1) begin errors++; $display("FAIL mp_discard got %b sq=%b exp %b sq=1", o_b, o_sq, 7'b0111011); end
    tick();
    checks++; if (o_b !== 7'b1101011 || o_sq !== 1'b0) begin errors++; $display("FAIL mp_resume got %b sq=%b exp %b sq=0", o_b, o_sq, 7'b1101011); end
    // back-to-back: second mispredict with fetch ready clears the pending squash
    ex_mispredict = 1; imem_ready = 0;
    tick();
    imem_ready = 1;
    tick();
    checks++; if (o_b !== 7'b1111111 || o_sq !== 1'b1) begin errors++; $display("FAIL mp_b2b got %b sq=%b exp %b sq=1", o_b, o_sq, 7'b1111111); end
    set_idle();
    tick();
    checks++; if (o_sq !== 1'b0) begin errors++; $display("FAIL mp_b2b_clear got sq=%b exp 0", o_sq); end
  endtask

  task automatic test_mem_wait();
    set_idle();
    mem_access = 1; dmem_ready = 0; ex_mispredict = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (o_b !== 7'b0000000) begin errors++; $display("FAIL mw_freeze%0d got %b exp 0000000", i, o_b); end
    end
    dmem_ready = 1;
    tick();
    checks++; if (o_st !== 2'd2 || o_b !== 7'b1111111) begin errors++; $display("FAIL mw_release got st=%0d %b exp st=2 %b", o_st, o_b, 7'b1111111); end
    set_idle();
    tick();
    checks++; if (o_st !== 2'd0) begin errors++; $display("FAIL mw_exit got %0d exp 0", o_st); end
  endtask

  task automatic test_luse_vs_mispredict();
    set_idle();
    ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_uses_rs1 = 1; ex_mispredict = 1;
    tick();
    checks++; if (o_b !== 7'b1111111) begin errors++; $display("FAIL mp_wins got %b exp %b", o_b, 7'b1111111); end
    set_idle();
    tick();
    checks++; if (o_st !== 2'd0) begin errors++; $display("FAIL mp_wins_state got %0d exp 0", o_st); end
  endtask

  task automatic test_reset_mid();
    set_idle();
    ex_mispredict = 1; imem_ready = 0;
    tick();
    ex_mispredict = 0; mem_access = 1; dmem_ready = 0;
    tick();
    tick();
    checks++; if (o_st !== 2'd2 || o_sq !== 1'b1) begin errors++; $display("FAIL rm_pre got st=%0d sq=%b exp st=2 sq=1", o_st, o_sq); end
    rst = 1;
    tick();
    checks++; if (o_b !== 7'b0010100) begin errors++; $display("FAIL rm_ctl got %b exp %b", o_b, 7'b0010100); end
    tick();
    checks++; if (o_st !== 2'd0 || o_sq !== 1'b0 || o_b !== 7'b0010100) begin errors++; $display("FAIL rm_after got st=%0d sq=%b %b exp st=0 sq=0 %b", o_st, o_sq, o_b, 7'b0010100); end
`ifdef HAZARD_PERF_CNT_EN
    checks++; if (o_stall !== '0 || o_flush !== '0) begin errors++; $display("FAIL rm_cnt got %0d/%0d exp 0/0", o_stall, o_flush); end
`endif
    set_idle();
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst           = ($urandom_range(0, 99) < 2);
      id_rs1        = RW'($urandom_range(0, 3));
      id_rs2        = RW'($urandom_range(0, 3));
      ex_rd         = RW'($urandom_range(0, 3));
      id_uses_rs1   = $urandom_range(0, 1);
      id_uses_rs2   = $urandom_range(0, 1);
      ex_mem_read   = ($urandom_range(0, 99) < 40);
      ex_mispredict = ($urandom_range(0, 99) < 15);
      imem_ready    = ($urandom_range(0, 99) < 70);
      mem_access    = ($urandom_range(0, 99) < 30);
      dmem_ready    = ($urandom_range(0, 99) < 60);
      tick();
      checks++; if (o_b !== e_b) begin errors++; $display("FAIL rnd_ctl[%0d] got %b exp %b", n, o_b, e_b); end
      checks++; if (o_st !== 2'(e_st) || o_sq !== e_sq) begin errors++; $display("FAIL rnd_state[%0d] got st=%0d sq=%b exp st=%0d sq=%b", n, o_st, o_sq, e_st, e_sq); end
`ifdef HAZARD_PERF_CNT_EN
      checks++; if (o_stall !== CW'(e_stall) || o_flush !== CW'(e_flush)) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d/%0d exp %0d/%0d", n, o_stall, o_flush, e_stall, e_flush); end
`endif
    end
  endtask

  initial begin
    set_idle();
    m_state = 0; m_sq = 0; m_stall = 0; m_flush = 0;
    test_reset();
    test_load_use();
    test_mispredict_squash();
    test_mem_wait();
    test_luse_vs_mispredict();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline. Drives the enable and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Inputs are load-use hazards, branch mispredicts resolved in EX, and instruction/data memory wait states. Tracks wrong-path fetches still in flight so they can be squashed.

Parameters:
RF_ADDR_W, 5, register-file address width
CNT_W, 16, width of the performance counters (PERF_CNT_EN only)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
id_rs1  in  RF_ADDR_W  rs1 of the instruction in ID
id_rs2  in  RF_ADDR_W  rs2 of the instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  RF_ADDR_W  destination of the instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_mispredict  in  1  branch/jump in EX resolved against its prediction
imem_ready  in  1  fetch data valid this cycle
mem_access  in  1  MEM stage holds a load/store
dmem_ready  in  1  data memory completes this cycle
pc_en  out  1  PC register load enable
ifid_en  out  1  IF/ID enable
ifid_flush  out  1  IF/ID clear; dominates ifid_en
idex_en  out  1  ID/EX enable
idex_flush  out  1  ID/EX clear; dominates idex_en
exmem_en  out  1  EX/MEM enable
memwb_en  out  1  MEM/WB enable
ctrl_state  out  2  registered state: 0 RUN, 1 LOAD_STALL, 2 MEM_WAIT
squash_pend  out  1  registered: a wrong-path fetch is in flight

Behaviour:
- Outputs are combinational from inputs, state and squash_pend. ctrl_state and squash_pend update on the rising edge of clk.
- Reset, sampled on clk while rst=1:
  - Outputs forced to: all enables 0, ifid_flush=1, idex_flush=1.
  - Next state RUN; squash_pend 0; counters 0.
- Conditions:
  - dstall = mem_access & ~dmem_ready
  - luse = ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))
- Strict priority, evaluated every cycle:
  1. dstall: all enables 0, no flushes. Whole pipe frozen; a mispredict is deferred, since EX holds it and it re-evaluates on release. Next state MEM_WAIT. squash_pend is held.
  2. ex_mispredict:
     - pc_en=1 (redirect); ifid_flush=1; idex_flush=1; idex_en, exmem_en, memwb_en = 1.
     - If imem_ready=0, set squash_pend; otherwise clear it.
     - Next state RUN.
  3. squash_pend=1 (no mispredict):
     - pc_en=0, ifid_flush=1; other enables 1.
     - When imem_ready=1 the wrong-path response is discarded: clear squash_pend. The PC stays at the target and the fetch reissues next cycle.
     - Next state RUN.
  4. luse: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1. Next state LOAD_STALL. The bubble removes the hazard, so the stall is exactly 1 cycle per load.
  5. ~imem_ready: pc_en=0, ifid_flush=1 (bubble into ID); downstream enables 1. Next state RUN.
  6. Otherwise all enables 1, no flushes. Next state RUN.
- x0 never causes a load-use stall.
- Back-to-back mispredicts keep squash_pend consistent: it is set or cleared per rule 2.
- rst during MEM_WAIT or with squash_pend=1 abandons both immediately.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[CNT_W-1:0] and flush_count[CNT_W-1:0].
  - stall_cycles increments each cycle pc_en=0 outside reset.
  - flush_count increments on each ex_mispredict cycle not masked by dstall.
  - Both saturate at all-ones; both reset to 0.
- Undefined: ports and counters are absent; core behaviour is identical.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum values RUN=0, LOAD_STALL=1, MEM_WAIT=2
  - localparam REG_X0=0
  - typedef for the 7-bit stage-control bundle
- One natural sub-module: hazard_luse_detect, the combinational luse compare. Reusable by the forwarding unit.
- FSM and priority logic stay in the top module.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle pc_en=0, ifid_en=0, idex_flush=1, ctrl_state=1; next cycle all enables 1.
- Same hazard with ex_rd=0 -> no stall, all enables 1.
- Mispredict with imem_ready=0 for 3 cycles -> cycle 0: pc_en=1, ifid_flush=1, idex_flush=1, squash_pend=1. Cycles 1-3: pc_en=0, ifid_flush=1. Cycle of imem_ready=1: squash_pend clears. Next cycle normal.
- mem_access=1, dmem_ready=0 for 4 cycles with ex_mispredict=1 -> 4 cycles all enables 0, ctrl_state=2; release cycle performs the flush.
- Simultaneous luse and ex_mispredict -> mispredict wins: pc_en=1, ifid_flush=1, no LOAD_STALL.
- rst=1 asserted mid MEM_WAIT with squash_pend=1 -> next cycle ctrl_state=0, squash_pend=0, flush outputs 1 while rst held. With HAZARD_PERF_CNT_EN, counters read 0.
